// File: rtl/lock_session_ctrl.sv
// lock_session_ctrl: session sequencer for the combination lock.
// Arms a BCD countdown on a button press and gates the open-code FSM.
// It counts failed attempts and forces a timed lockout after MAX_FAILS failures.
// Optional feature: define LOCK_AUTORELOCK_EN to make OPEN relock by itself
// after AUTO_CLOSE_SEC ticks.
module lock_session_ctrl #(
  parameter int SESSION_SEC    = 60,
  parameter int LOCKOUT_SEC    = 30,
  parameter int MAX_FAILS      = 3,
  parameter int AUTO_CLOSE_SEC = 10
) (
  input  logic       i_clock,
  input  logic       i_rst_n,
  input  logic       i_tick_1hz,
  input  logic       i_pb_pulse,
  input  logic       i_code_ok,
  input  logic       i_code_bad,
  input  logic       i_close_done,
  output logic       o_session_active,
  output logic       o_open,
  output logic       o_locked_out,
  output logic       o_fsm_clear,
  output logic [3:0] o_timer_msd,
  output logic [3:0] o_timer_lsd,
  output logic [2:0] o_attempts_left
);

  typedef enum logic [1:0] {IDLE, ARMED, OPEN, LOCKOUT} state_t;

  localparam logic [7:0] SES_BCD  = {4'(SESSION_SEC / 10), 4'(SESSION_SEC % 10)};
  localparam logic [7:0] LOCK_BCD = {4'(LOCKOUT_SEC / 10), 4'(LOCKOUT_SEC % 10)};
  localparam logic [2:0] MAX_ATT  = 3'(MAX_FAILS);
`ifdef LOCK_AUTORELOCK_EN
  localparam logic [7:0] OPEN_BCD = {4'(AUTO_CLOSE_SEC / 10), 4'(AUTO_CLOSE_SEC % 10)};
`else
  localparam logic [7:0] OPEN_BCD = SES_BCD;
  logic w_unused_auto;
  assign w_unused_auto = (AUTO_CLOSE_SEC > 0);
`endif

  // Two-digit BCD decrement; holds at 00 so the timer can never underflow.
  function automatic logic [7:0] bcd_dec(input logic [7:0] t);
    logic [3:0] msd;
    logic [3:0] lsd;
    msd = t[7:4];
    lsd = t[3:0];
    if (t == 8'h00) begin
      bcd_dec = 8'h00;
    end else if (lsd == 4'd0) begin
      bcd_dec = {msd - 4'd1, 4'd9};
    end else begin
      bcd_dec = {msd, lsd - 4'd1};
    end
  endfunction

  state_t     r_state;
  logic [7:0] r_timer;
  logic [2:0] r_att;
  logic       r_fsm_clear;
  logic       r_session_active;
  logic       r_open;
  logic       r_locked_out;

  state_t     w_state_nxt;
  logic [7:0] w_timer_nxt;
  logic [2:0] w_att_nxt;
  logic       w_clr_req;
  logic       w_clr_nxt;
  logic [7:0] w_dec;
  logic       w_at_one;
  logic       w_last_try;

  // Next-state, timer and attempt-counter decisions for the session FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_att_nxt   = r_att;
    w_clr_req   = 1'b0;
    w_dec       = bcd_dec(r_timer);
    w_at_one    = (r_timer == 8'h01);
    w_last_try  = (r_att <= 3'd1);
    case (r_state)
      IDLE: begin
        w_timer_nxt = SES_BCD;
        if (i_pb_pulse) begin
          w_state_nxt = ARMED;
          w_clr_req   = 1'b1;
        end
      end
      ARMED: begin
        if (i_code_ok) begin
          w_state_nxt = OPEN;
          w_att_nxt   = MAX_ATT;
          w_timer_nxt = OPEN_BCD;
        end else if (i_code_bad) begin
          w_clr_req = 1'b1;
          // A plain tick still counts down; an expiring tick yields to code_bad.
          if (i_tick_1hz && !w_at_one) w_timer_nxt = w_dec;
          if (w_last_try) begin
            w_state_nxt = LOCKOUT;
            w_att_nxt   = 3'd0;
            w_timer_nxt = LOCK_BCD;
          end else begin
            w_att_nxt = r_att - 3'd1;
          end
        end else if (i_tick_1hz) begin
          if (!w_at_one) begin
            w_timer_nxt = w_dec;
          end else if (w_last_try) begin
            w_state_nxt = LOCKOUT;
            w_att_nxt   = 3'd0;
            w_timer_nxt = LOCK_BCD;
          end else begin
            w_state_nxt = IDLE;
            w_att_nxt   = r_att - 3'd1;
            w_timer_nxt = SES_BCD;
          end
        end
      end
      OPEN: begin
`ifdef LOCK_AUTORELOCK_EN
        if (i_close_done || (i_tick_1hz && w_at_one)) begin
          w_state_nxt = IDLE;
          w_timer_nxt = SES_BCD;
        end else if (i_tick_1hz) begin
          w_timer_nxt = w_dec;
        end
`else
        w_timer_nxt = SES_BCD;
        if (i_close_done) w_state_nxt = IDLE;
`endif
      end
      LOCKOUT: begin
        if (i_tick_1hz) begin
          if (w_at_one) begin
            w_state_nxt = IDLE;
            w_att_nxt   = MAX_ATT;
            w_timer_nxt = SES_BCD;
            w_clr_req   = 1'b1;
          end else begin
            w_timer_nxt = w_dec;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = SES_BCD;
        w_att_nxt   = MAX_ATT;
      end
    endcase
    // The clear pulse is suppressed when one was issued the previous cycle.
    w_clr_nxt = w_clr_req & ~r_fsm_clear;
  end

  // State, timer, counter and registered status outputs.
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_timer          <= SES_BCD;
      r_att            <= MAX_ATT;
      r_fsm_clear      <= 1'b0;
      r_session_active <= 1'b0;
      r_open           <= 1'b0;
      r_locked_out     <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_timer          <= w_timer_nxt;
      r_att            <= w_att_nxt;
      r_fsm_clear      <= w_clr_nxt;
      r_session_active <= (w_state_nxt == ARMED);
      r_open           <= (w_state_nxt == OPEN);
      r_locked_out     <= (w_state_nxt == LOCKOUT);
    end
  end

  assign o_session_active = r_session_active;
  assign o_open           = r_open;
  assign o_locked_out     = r_locked_out;
  assign o_fsm_clear      = r_fsm_clear;
  assign o_timer_msd      = r_timer[7:4];
  assign o_timer_lsd      = r_timer[3:0];
  assign o_attempts_left  = r_att;

endmodule

// File: tb/tb_lock_session_ctrl.sv
// Testbench for lock_session_ctrl with default parameters (60/30/3/10).
// Directed vector table plus hand-written multi-cycle sequences.
module tb_lock_session_ctrl;

  logic       clk;
  logic       rst_n, tick, pb, ok, bad, cls;
  logic       sa, opn, lo, clr;
  logic [3:0] msd, lsd;
  logic [2:0] att;

  int n_checks;
  int n_pass;

`ifdef LOCK_AUTORELOCK_EN
  localparam logic [3:0] OM = 4'd1, OL = 4'd0;
`else
  localparam logic [3:0] OM = 4'd6, OL = 4'd0;
`endif

  lock_session_ctrl dut (
    .i_clock(clk), .i_rst_n(rst_n), .i_tick_1hz(tick), .i_pb_pulse(pb),
    .i_code_ok(ok), .i_code_bad(bad), .i_close_done(cls),
    .o_session_active(sa), .o_open(opn), .o_locked_out(lo), .o_fsm_clear(clr),
    .o_timer_msd(msd), .o_timer_lsd(lsd), .o_attempts_left(att)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs: rst_n tick pb ok bad close ; outputs: sa open lo clr msd lsd att
  typedef struct {
    logic [5:0]  in;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[24];

  function automatic logic [14:0] pk(input logic s, o, l, c,
                                     input logic [3:0] m, u, input logic [2:0] a);
    pk = {s, o, l, c, m, u, a};
  endfunction

  function automatic logic [14:0] cur();
    cur = {sa, opn, lo, clr, msd, lsd, att};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got sa/op/lo/clr/msd/lsd/att=%b/%b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%b/%0d/%0d/%0d",
                  name, act[14], act[13], act[12], act[11], act[10:7], act[6:3], act[2:0],
                  exp[14], exp[13], exp[12], exp[11], exp[10:7], exp[6:3], exp[2:0]);
  endtask

  // One clock with the given inputs; outputs settle 1 time unit after the edge.
  task automatic step(input logic [5:0] in);
    @(negedge clk);
    {rst_n, tick, pb, ok, bad, cls} = in;
    @(posedge clk);
    #1;
    {tick, pb, ok, bad, cls} = 5'b0;
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(6'b110000);
  endtask

  localparam logic [5:0] NOP = 6'b100000, RST = 6'b000000, TCK = 6'b110000,
                         PB = 6'b101000, OK = 6'b100100, BAD = 6'b100010,
                         CLS = 6'b100001;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    {rst_n, tick, pb, ok, bad, cls} = 6'b0;

    tbl[0]  = '{RST,              pk(0,0,0,0,6,0,3)};
    tbl[1]  = '{TCK,              pk(0,0,0,0,6,0,3)};
    tbl[2]  = '{PB,               pk(1,0,0,1,6,0,3)};
    tbl[3]  = '{NOP,              pk(1,0,0,0,6,0,3)};
    tbl[4]  = '{PB,               pk(1,0,0,0,6,0,3)};
    tbl[5]  = '{TCK,              pk(1,0,0,0,5,9,3)};
    tbl[6]  = '{TCK,              pk(1,0,0,0,5,8,3)};
    tbl[7]  = '{BAD,              pk(1,0,0,1,5,8,2)};
    tbl[8]  = '{NOP,              pk(1,0,0,0,5,8,2)};
    tbl[9]  = '{BAD | TCK,        pk(1,0,0,1,5,7,1)};
    tbl[10] = '{NOP,              pk(1,0,0,0,5,7,1)};
    tbl[11] = '{OK,               pk(0,1,0,0,OM,OL,3)};
    tbl[12] = '{PB | OK | BAD,    pk(0,1,0,0,OM,OL,3)};
    tbl[13] = '{CLS,              pk(0,0,0,0,6,0,3)};
    tbl[14] = '{PB,               pk(1,0,0,1,6,0,3)};
    tbl[15] = '{NOP,              pk(1,0,0,0,6,0,3)};
    tbl[16] = '{BAD,              pk(1,0,0,1,6,0,2)};
    tbl[17] = '{NOP,              pk(1,0,0,0,6,0,2)};
    tbl[18] = '{BAD,              pk(1,0,0,1,6,0,1)};
    tbl[19] = '{NOP,              pk(1,0,0,0,6,0,1)};
    tbl[20] = '{BAD,              pk(0,0,1,1,3,0,0)};
    tbl[21] = '{PB | OK | CLS,    pk(0,0,1,0,3,0,0)};
    tbl[22] = '{TCK,              pk(0,0,1,0,2,9,0)};
    tbl[23] = '{RST | 6'b011111,  pk(0,0,0,0,6,0,3)};

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), cur(), tbl[i].exp);
    end

    // Session expiries: BCD borrow, three timeouts into lockout, lockout exit.
    step(PB);
    ticks(10);  check("cnt_50", cur(), pk(1,0,0,0,5,0,3));
    ticks(1);   check("cnt_49", cur(), pk(1,0,0,0,4,9,3));
    ticks(48);  check("cnt_01", cur(), pk(1,0,0,0,0,1,3));
    ticks(1);   check("expire1", cur(), pk(0,0,0,0,6,0,2));
    step(PB); ticks(60); check("expire2", cur(), pk(0,0,0,0,6,0,1));
    step(PB); ticks(60); check("expire3_lock", cur(), pk(0,0,1,0,3,0,0));
    ticks(29);  check("lock_01", cur(), pk(0,0,1,0,0,1,0));
    ticks(1);   check("lock_exit", cur(), pk(0,0,0,1,6,0,3));
    step(NOP);  check("lock_exit_clr", cur(), pk(0,0,0,0,6,0,3));

    // code_ok wins over an expiring tick.
    step(PB); ticks(59);
    step(OK | TCK); check("ok_at_01", cur(), pk(0,1,0,0,OM,OL,3));
    step(CLS);      check("close", cur(), pk(0,0,0,0,6,0,3));

    // code_bad alongside a plain tick at 07.
    step(PB); ticks(53); check("cnt_07", cur(), pk(1,0,0,0,0,7,3));
    step(BAD | TCK);     check("bad_tick_07", cur(), pk(1,0,0,1,0,6,2));

    // Reset in the middle of a lockout.
    step(RST);
    step(PB); step(BAD); step(NOP); step(BAD); step(NOP); step(BAD);
    ticks(15); check("lock_15", cur(), pk(0,0,1,0,1,5,0));
    step(RST); check("rst_in_lock", cur(), pk(0,0,0,0,6,0,3));

    // OPEN hold versus auto-relock.
    step(PB); step(OK);
`ifdef LOCK_AUTORELOCK_EN
    ticks(9);  check("auto_01", cur(), pk(0,1,0,0,0,1,3));
    ticks(1);  check("auto_relock", cur(), pk(0,0,0,0,6,0,3));
`else
    ticks(100); check("open_hold", cur(), pk(0,1,0,0,6,0,3));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
